// File: rtl/clock_counter_cfg.sv
// clock_counter_cfg: BCD hh:mm:ss counter with prescaler, 12h/24h mode, time-set load and alarm compare
module clock_counter_cfg #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DIV_W      = 26,
  parameter bit MODE24_DEF = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mode24,
  input  logic       set_en,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  input  logic       alm_en,
  input  logic [7:0] alm_min,
  input  logic [7:0] alm_hour,
  output logic [3:0] sec_1,
  output logic [3:0] sec_2,
  output logic [3:0] min_1,
  output logic [3:0] min_2,
  output logic [3:0] hour_1,
  output logic [3:0] hour_2,
  output logic       tick,
  output logic       oc_sec,
  output logic       oc_min,
  output logic       alarm
);
  localparam logic [DIV_W-1:0] LAST     = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       HOUR_RST = MODE24_DEF ? 8'h00 : 8'h12;
  logic [DIV_W-1:0] pre, pre_n;
  logic             mode_q;
  logic [7:0]       sec, min, hour;
  logic [7:0]       sec_n, min_n, hour_n, hour_cv, hour_inc;
  logic             tick_c, sec_wrap, min_wrap, sec_ok, min_ok, hour_ok;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  assign {sec_2, sec_1}   = sec;
  assign {min_2, min_1}   = min;
  assign {hour_2, hour_1} = hour;
  // next-state: prescaler, mode conversion, load validation and BCD increment chain
  always_comb begin
    tick_c   = run && pre == LAST && !set_en;
    pre_n    = set_en ? '0 : !run ? pre : (pre == LAST) ? '0 : pre + 1'b1;
    sec_wrap = sec == 8'h59;
    min_wrap = min == 8'h59;
    hour_cv  = (mode24 == mode_q) ? hour :
               mode24 ? ((hour == 8'h12) ? 8'h00 : hour) :
               (hour == 8'h00) ? 8'h12 :
               (hour < 8'h13)  ? hour :
               (hour < 8'h20)  ? {4'h0, hour[3:0] - 4'd2} :
               (hour < 8'h22)  ? {4'h0, hour[3:0] + 4'd8} :
                                 {4'h1, hour[3:0] - 4'd2};
    hour_inc = mode24 ? ((hour_cv == 8'h23) ? 8'h00 : bcd_inc(hour_cv))
                      : ((hour_cv == 8'h12) ? 8'h01 : bcd_inc(hour_cv));
    sec_ok   = set_sec[3:0] <= 4'd9 && set_sec[7:4] <= 4'd5;
    min_ok   = set_min[3:0] <= 4'd9 && set_min[7:4] <= 4'd5;
    hour_ok  = set_hour[3:0] <= 4'd9 &&
               (mode24 ? set_hour <= 8'h23 : (set_hour != 8'h00 && set_hour <= 8'h12));
    sec_n    = set_en ? (sec_ok ? set_sec : sec) :
               tick_c ? (sec_wrap ? 8'h00 : bcd_inc(sec)) : sec;
    min_n    = set_en ? (min_ok ? set_min : min) :
               (tick_c && sec_wrap) ? (min_wrap ? 8'h00 : bcd_inc(min)) : min;
    hour_n   = set_en ? (hour_ok ? set_hour : hour_cv) :
               (tick_c && sec_wrap && min_wrap) ? hour_inc : hour_cv;
  end
  // state and registered strobes; tick looks ahead so it is high while the prescaler sits at its last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      mode_q <= MODE24_DEF;
      sec    <= 8'h00;
      min    <= 8'h00;
      hour   <= HOUR_RST;
      tick   <= 1'b0;
      oc_sec <= 1'b0;
      oc_min <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      pre    <= pre_n;
      mode_q <= mode24;
      sec    <= sec_n;
      min    <= min_n;
      hour   <= hour_n;
      tick   <= run && pre_n == LAST;
      oc_sec <= tick_c && sec_wrap;
      oc_min <= tick_c && sec_wrap && min_wrap;
      alarm  <= alm_en && hour == alm_hour && min == alm_min;
    end
  end
endmodule

// File: tb/tb_clock_counter_cfg.sv
// tb_clock_counter_cfg: scoreboard bench with an integer time-of-day reference model
module tb_clock_counter_cfg;
  localparam int TD = 4;
  logic       clk = 1'b0, rst_n = 1'b0, run = 1'b0, mode24 = 1'b0, set_en = 1'b0, alm_en = 1'b0;
  logic [7:0] set_sec = '0, set_min = '0, set_hour = '0, alm_min = '0, alm_hour = '0;
  logic [3:0] sec_1, sec_2, min_1, min_2, hour_1, hour_2;
  logic       tick, oc_sec, oc_min, alarm;
  typedef struct packed {
    logic [7:0] h, m, s;
    logic       t, os, om, al;
  } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0;
  int   ms, mm, mh, mpre;
  bit   mmode, mtick, mos, mom, mal;

  clock_counter_cfg #(.TICK_DIV(TD), .DIV_W(3), .MODE24_DEF(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode24(mode24), .set_en(set_en),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .alm_en(alm_en), .alm_min(alm_min), .alm_hour(alm_hour),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2), .tick(tick), .oc_sec(oc_sec),
    .oc_min(oc_min), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [23:0] now_time();
    return {hour_2, hour_1, min_2, min_1, sec_2, sec_1};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; mm = 0; mh = 12; mpre = 0; mmode = 1'b0;
    mtick = 1'b0; mos = 1'b0; mom = 1'b0; mal = 1'b0;
  endtask

  // Advances the reference model by one clock using the inputs currently driven
  task automatic model_step();
    bit tk, al;
    int st, so, mt, mo, ht, ho, hv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = run && mpre == TD - 1 && !set_en;
    al = alm_en && bcd(mh) == alm_hour && bcd(mm) == alm_min;
    if (mode24 != mmode) begin
      if (mode24) mh = (mh == 12) ? 0 : mh;
      else mh = (mh == 0) ? 12 : (mh > 12) ? mh - 12 : mh;
      mmode = mode24;
    end
    mos = 1'b0;
    mom = 1'b0;
    if (set_en) begin
      st = set_sec[7:4]; so = set_sec[3:0];
      mt = set_min[7:4]; mo = set_min[3:0];
      ht = set_hour[7:4]; ho = set_hour[3:0];
      hv = ht * 10 + ho;
      if (st <= 5 && so <= 9) ms = st * 10 + so;
      if (mt <= 5 && mo <= 9) mm = mt * 10 + mo;
      if (ho <= 9 && (mmode ? hv <= 23 : (hv >= 1 && hv <= 12))) mh = hv;
      mpre = 0;
    end else begin
      if (tk) begin
        ms++;
        if (ms == 60) begin
          ms = 0; mos = 1'b1; mm++;
          if (mm == 60) begin
            mm = 0; mom = 1'b1;
            mh = mmode ? (mh + 1) % 24 : mh % 12 + 1;
          end
        end
      end
      if (run) mpre = (mpre + 1) % TD;
    end
    mtick = run && mpre == TD - 1;
    mal = al;
  endtask

  task automatic cycle();
    model_step();
    q.push_back('{bcd(mh), bcd(mm), bcd(ms), mtick, mos, mom, mal});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    set_hour = h; set_min = m; set_sec = s; set_en = 1'b1;
    cycle();
    set_en = 1'b0;
  endtask

  // Scoreboard monitor: every clock the DUT presents a full output word
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{{hour_2, hour_1}, {min_2, min_1}, {sec_2, sec_1}, tick, oc_sec, oc_min, alarm};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard got h=%h m=%h s=%h t=%b os=%b om=%b al=%b expected h=%h m=%h s=%h t=%b os=%b om=%b al=%b at %0t",
                 a.h, a.m, a.s, a.t, a.os, a.om, a.al, e.h, e.m, e.s, e.t, e.os, e.om, e.al, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    cycle();
    chk("reset_time", now_time(), 24'h120000);
    rst_n = 1'b1; run = 1'b1;
    cycles(16);
    chk("four_ticks", now_time(), 24'h120004);
    run = 1'b0;
    cycles(5);
    chk("run_hold", now_time(), 24'h120004);
    run = 1'b1;
    load(8'h12, 8'h59, 8'h59);
    cycles(4);
    chk("wrap_12h", now_time(), 24'h010000);
    chk("oc_pair", {oc_sec, oc_min}, 2'b11);
    cycle();
    chk("oc_one_cycle", {oc_sec, oc_min}, 2'b00);
    mode24 = 1'b1;
    cycle();
    load(8'h23, 8'h59, 8'h59);
    cycles(4);
    chk("wrap_24h", now_time(), 24'h000000);
    load(8'h09, 8'h59, 8'h59);
    cycles(4);
    chk("nine_to_ten", now_time(), 24'h100000);
    cycles(3);
    load(8'h05, 8'h30, 8'h15);
    chk("set_over_tick", now_time(), 24'h053015);
    chk("set_no_pulse", {tick, oc_sec, oc_min}, 3'b000);
    mode24 = 1'b0;
    load(8'h13, 8'h10, 8'h20);
    chk("bad_hour_12h", now_time(), 24'h051020);
    run = 1'b0; mode24 = 1'b1;
    cycle();
    load(8'h15, 8'h20, 8'h00);
    mode24 = 1'b0;
    cycle();
    chk("conv_15_to_03", now_time(), 24'h032000);
    mode24 = 1'b1;
    cycle();
    load(8'h00, 8'h11, 8'h00);
    mode24 = 1'b0;
    cycle();
    chk("conv_00_to_12", now_time(), 24'h121100);
    mode24 = 1'b1; alm_en = 1'b1; alm_hour = 8'h07; alm_min = 8'h45; run = 1'b1;
    load(8'h07, 8'h44, 8'h59);
    cycles(4);
    chk("alarm_reach", {now_time(), 7'd0, alarm}, {24'h074500, 8'h00});
    cycle();
    chk("alarm_rise", alarm, 1);
    cycles(239);
    chk("alarm_minute_end", {now_time(), 7'd0, alarm}, {24'h074600, 8'h01});
    cycle();
    chk("alarm_fall", alarm, 0);
    load(8'h07, 8'h45, 8'h30);
    cycles(3);
    chk("alarm_before_rst", alarm, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {now_time(), 5'd0, tick, oc_sec, alarm}, {24'h120000, 8'h00});
    cycle();
    rst_n = 1'b1; mode24 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      run = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) mode24 = ~mode24;
      set_en = $urandom_range(0, 39) == 0;
      set_sec  = $urandom_range(0, 3) == 0 ? 8'($urandom) : bcd($urandom_range(45, 59));
      set_min  = $urandom_range(0, 3) == 0 ? 8'($urandom) : bcd($urandom_range(55, 59));
      set_hour = $urandom_range(0, 3) == 0 ? 8'($urandom) : bcd($urandom_range(0, 23));
      if ($urandom_range(0, 9) == 0) alm_en = ~alm_en;
      if ($urandom_range(0, 29) == 0) begin
        alm_hour = bcd(mh); alm_min = bcd(mm);
      end
      rst_n = $urandom_range(0, 499) != 0;
      cycle();
      set_en = 1'b0;
      rst_n = 1'b1;
    end
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
